// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply sequencer and ALU control:
// ALU signal encodings, sequencer state encoding and the default datapath width.
package mul_seq_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ALU_SIG_W    = 4;

    localparam logic [ALU_SIG_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_SIG_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_SIG_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_SIG_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_SIG_W-1:0] ALU_SLT = 4'd4;
    localparam logic [ALU_SIG_W-1:0] ALU_MUL = 4'd5;
    localparam logic [ALU_SIG_W-1:0] ALU_XOR = 4'd6;
    localparam logic [ALU_SIG_W-1:0] ALU_SL  = 4'd7;
    localparam logic [ALU_SIG_W-1:0] ALU_SRA = 4'd8;
    localparam logic [ALU_SIG_W-1:0] ALU_SRL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // True when the EX instruction is a live multiply that may start the sequencer.
    function automatic logic mul_start(input logic valid, input logic flush,
                                       input logic [ALU_SIG_W-1:0] sig,
                                       input logic [ALU_SIG_W-1:0] code);
        return valid && !flush && (sig == code);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage <-> multiply sequencer signal bundle; master is the pipeline side,
// slave is the sequencer.
interface mul_seq_ctrl_if
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic                 valid_i;
    logic                 flush_i;
    logic                 hold_i;
    logic [ALU_SIG_W-1:0] alu_signal_i;
    logic [XLEN-1:0]      rs1_i;
    logic [XLEN-1:0]      rs2_i;
    logic                 stall_o;
    logic                 busy_o;
    logic [XLEN-1:0]      result_o;
    logic                 result_valid_o;

    modport master (
        output valid_i, flush_i, hold_i, alu_signal_i, rs1_i, rs2_i,
        input  stall_o, busy_o, result_o, result_valid_o
    );

    modport slave (
        input  valid_i, flush_i, hold_i, alu_signal_i, rs1_i, rs2_i,
        output stall_o, busy_o, result_o, result_valid_o
    );
endinterface

// File: rtl/mul_seq_ctrl_step.sv
// One shift-add step: adds mcand * slice (BPC multiplier bits) into the
// accumulator, keeping only the low XLEN bits.
module mul_seq_ctrl_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 4
) (
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] mcand_i,
    input  logic [BPC-1:0]  slice_i,
    output logic [XLEN-1:0] acc_o
);
    logic [XLEN-1:0] pp;

    always_comb begin
        pp = '0;
        for (int unsigned b = 0; b < BPC; b++) begin
            if (slice_i[b]) pp = pp + (mcand_i << b);
        end
    end

    assign acc_o = acc_i + pp;
endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative low-word multiply sequencer for the EX-stage MUL op.
// Optional build macro: MUL_EARLY_OUT_EN (finish as soon as the remaining multiplier is zero).
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned          XLEN     = XLEN_DEFAULT,
    parameter int unsigned          BPC      = 4,
    parameter logic [ALU_SIG_W-1:0] MUL_CODE = ALU_MUL
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_seq_ctrl_if.slave bus
);
    localparam int unsigned      ITER     = XLEN / BPC;
    localparam int unsigned      CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mul_state_e      state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] acc_step;
    logic            start;
    logic            last_iter;
    logic            stall_c;
    logic            rvalid_c;

    mul_seq_ctrl_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[BPC-1:0]),
        .acc_o   (acc_step)
    );

    assign start = mul_start(bus.valid_i, bus.flush_i, bus.alu_signal_i, MUL_CODE);

`ifdef MUL_EARLY_OUT_EN
    assign last_iter = (cnt_q == CNT_LAST) || ((mplier_q >> BPC) == '0);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    // Next-state, datapath update and combinational handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        stall_c  = 1'b0;
        rvalid_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = bus.rs1_i;
                    mplier_d = bus.rs2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    stall_c  = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_c  = 1'b1;
                acc_d    = acc_step;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = acc_step;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // The same MUL still sits in EX here, so start is never consulted.
                rvalid_c = 1'b1;
                if (!bus.hold_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush_i) begin
            state_d  = ST_IDLE;
            stall_c  = 1'b0;
            rvalid_c = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    // Reset must not leak a stall from a MUL decoded while reset is held.
    assign bus.stall_o        = stall_c & ~rst_i;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = rvalid_c;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (XLEN=32, BPC=4).
module tb_mul_seq_ctrl;
    localparam int unsigned XLEN = 32;
    localparam int unsigned BPC  = 4;
    localparam int unsigned ITER = XLEN / BPC;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[8];

    mul_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    mul_seq_ctrl #(.XLEN(XLEN), .BPC(BPC), .MUL_CODE(4'd5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_iters(input logic [31:0] b);
        int n;
        n = ITER;
`ifdef MUL_EARLY_OUT_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i / BPC + 1;
`endif
        return n;
    endfunction

    task automatic drive(input logic v, input logic [3:0] sig, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic hd);
        bus.valid_i      = v;
        bus.alu_signal_i = sig;
        bus.rs1_i        = a;
        bus.rs2_i        = b;
        bus.flush_i      = fl;
        bus.hold_i       = hd;
    endtask

    // Full MUL from the start cycle T to the first result cycle; hd is hold_i in that cycle.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic hd);
        int n;
        n = exp_iters(b);
        @(negedge clk);
        drive(1'b1, 4'd5, a, b, 1'b0, 1'b0);
        #1;
        chk("start_busy", 32'(bus.busy_o), 32'd0);
        chk("start_stall", 32'(bus.stall_o), 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            #1;
            chk("busy_stall", 32'(bus.stall_o), 32'd1);
            chk("busy_rvalid", 32'(bus.result_valid_o), 32'd0);
        end
        @(negedge clk);
        bus.hold_i = hd;
        #1;
        chk("done_stall", 32'(bus.stall_o), 32'd0);
        chk("done_rvalid", 32'(bus.result_valid_o), 32'd1);
        chk("done_result", bus.result_o, p);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_stall", 32'(bus.stall_o), 32'd0);
        chk("idle_rvalid", 32'(bus.result_valid_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{a: 32'd7,          b: 32'd6,          p: 32'd42};
        vecs[1] = '{a: 32'hFFFFFFFD,   b: 32'd5,          p: 32'hFFFFFFF1};
        vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   p: 32'h00000001};
        vecs[3] = '{a: 32'h12345678,   b: 32'd9,          p: 32'hA3D70A38};
        vecs[4] = '{a: 32'h00010000,   b: 32'h00010000,   p: 32'h00000000};
        vecs[5] = '{a: 32'h80000000,   b: 32'd2,          p: 32'h00000000};
        vecs[6] = '{a: 32'd1234,       b: 32'd0,          p: 32'h00000000};
        vecs[7] = '{a: 32'd1,          b: 32'h80000000,   p: 32'h80000000};

        drive(1'b1, 4'd5, 32'd3, 32'd3, 1'b0, 1'b0);
        #2;
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_rvalid", 32'(bus.result_valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
            idle_cycle();
        end

        // Back-to-back MULs: second starts in the cycle right after DONE.
        do_mul(32'd3, 32'd4, 32'd12, 1'b0);
        do_mul(32'd5, 32'd5, 32'd25, 1'b0);
        idle_cycle();

        // Hold entering DONE: result held for 4 cycles with no restart.
        do_mul(32'd11, 32'd13, 32'd143, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("hold_rvalid", 32'(bus.result_valid_o), 32'd1);
            chk("hold_result", bus.result_o, 32'd143);
            chk("hold_stall", 32'(bus.stall_o), 32'd0);
        end
        @(negedge clk);
        bus.hold_i = 1'b0;
        #1;
        chk("hold_last_rvalid", 32'(bus.result_valid_o), 32'd1);
        chk("hold_last_result", bus.result_o, 32'd143);
        idle_cycle();

        // Flush at T+4 aborts the multiply with no result pulse.
        @(negedge clk);
        drive(1'b1, 4'd5, 32'd9, 32'd9, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) @(negedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(bus.stall_o), 32'd0);
        chk("flush_rvalid", 32'(bus.result_valid_o), 32'd0);
        for (int k = 0; k < ITER + 2; k++) idle_cycle();

        // Non-MUL instruction never stalls.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 4'd0, 32'd7, 32'd6, 1'b0, 1'b0);
            #1;
            chk("add_stall", 32'(bus.stall_o), 32'd0);
            chk("add_busy", 32'(bus.busy_o), 32'd0);
        end

        // Reset mid-BUSY clears everything immediately.
        @(negedge clk);
        drive(1'b1, 4'd5, 32'd1000, 32'hFFFFFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_stall", 32'(bus.stall_o), 32'd0);
        chk("mrst_busy", 32'(bus.busy_o), 32'd0);
        chk("mrst_rvalid", 32'(bus.result_valid_o), 32'd0);
        chk("mrst_result", bus.result_o, 32'd0);
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_cycle();

        // Fresh MUL after reset still works.
        do_mul(32'd7, 32'd6, 32'd42, 1'b0);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
